// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared widths and FSM state encoding for the data-memory arbiter.
// DMEM_ARB_RR_EN is undefined by default, which builds the fixed-priority arbiter.
package dmem_arbiter_pkg;
    localparam int ADDR_SIZE = 32;
    localparam int WORD_SIZE = 32;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;
endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: winner select for two requesters (round-robin when DMEM_ARB_RR_EN is defined).
module dmem_arb_pick (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic upd,
    output logic sel
);
`ifdef DMEM_ARB_RR_EN
    logic last_p1;
    // p1 wins alone, or on a tie when p0 was the last one served
    always_comb sel = req1 && (!req0 || !last_p1);
    // remember who was granted last; reset state makes p0 win the first tie
    always_ff @(posedge clk)
        if (rst) last_p1 <= 1'b1;
        else if (upd) last_p1 <= sel;
`else
    logic unused_pick;
    assign unused_pick = clk ^ rst ^ upd;
    // fixed priority: p0 always wins
    always_comb sel = !req0 && req1;
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester data-memory arbiter; define DMEM_ARB_RR_EN for round-robin arbitration.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DEPTH_WORDS = 32,
    parameter int DEBUG = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 p0_req,
    input  logic                 p0_we,
    input  logic [ADDR_SIZE-1:0] p0_addr,
    input  logic [WORD_SIZE-1:0] p0_wdata,
    output logic                 p0_gnt,
    output logic                 p0_done,
    output logic                 p0_err,
    output logic [WORD_SIZE-1:0] p0_rdata,
    input  logic                 p1_req,
    input  logic                 p1_we,
    input  logic [ADDR_SIZE-1:0] p1_addr,
    input  logic [WORD_SIZE-1:0] p1_wdata,
    output logic                 p1_gnt,
    output logic                 p1_done,
    output logic                 p1_err,
    output logic [WORD_SIZE-1:0] p1_rdata,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_dta_write,
    output logic                 mem_read,
    output logic                 mem_write,
    input  logic [WORD_SIZE-1:0] mem_dta_out
);
    state_t state, next;
    logic sel, any, start, bad, w_we;
    logic [ADDR_SIZE-1:0] w_addr;
    logic lat_sel, lat_we;
    logic [ADDR_SIZE-1:0] lat_addr;
    logic [WORD_SIZE-1:0] lat_wdata;
    logic unused_debug;

    // error events are reported through pN_err; DEBUG has no hardware effect
    assign unused_debug = DEBUG != 0;

    dmem_arb_pick u_pick (
        .clk (clk),
        .rst (rst),
        .req0(p0_req),
        .req1(p1_req),
        .upd (start),
        .sel (sel)
    );

    // winner's request fields and address legality, evaluated during IDLE
    always_comb begin
        any = p0_req || p1_req;
        start = state == IDLE && any;
        w_we = sel ? p1_we : p0_we;
        w_addr = sel ? p1_addr : p0_addr;
        bad = w_addr[1:0] != 2'b00 || (w_addr >> 2) >= ADDR_SIZE'(DEPTH_WORDS);
    end

    // state register
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= next;

    // next state: IDLE -> ACCESS/ERR on a request, everything else returns towards IDLE
    always_comb
        next = state == IDLE   ? (any ? (bad ? ERR : ACCESS) : IDLE) :
               state == ACCESS ? RESP : IDLE;

    // registered outputs: each is one cycle behind the state that produces it,
    // so strobes appear the cycle after ACCESS and done the cycle after RESP/ERR
    always_ff @(posedge clk)
        if (rst) begin
            {p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err} <= '0;
            {mem_read, mem_write} <= '0;
            mem_addr <= '0;
            mem_dta_write <= '0;
            p0_rdata <= '0;
            p1_rdata <= '0;
            {lat_sel, lat_we} <= '0;
            lat_addr <= '0;
            lat_wdata <= '0;
        end else begin
            if (start) begin
                lat_sel <= sel;
                lat_we <= w_we;
                lat_addr <= w_addr;
                lat_wdata <= sel ? p1_wdata : p0_wdata;
            end
            p0_gnt <= start && !sel;
            p1_gnt <= start && sel;
            mem_read <= state == ACCESS && !lat_we;
            mem_write <= state == ACCESS && lat_we;
            mem_addr <= state == ACCESS ? lat_addr : '0;
            mem_dta_write <= state == ACCESS ? lat_wdata : '0;
            p0_done <= (state == RESP || state == ERR) && !lat_sel;
            p1_done <= (state == RESP || state == ERR) && lat_sel;
            p0_err <= state == ERR && !lat_sel;
            p1_err <= state == ERR && lat_sel;
            if (state == RESP && !lat_we && !lat_sel) p0_rdata <= mem_dta_out;
            if (state == RESP && !lat_we && lat_sel) p1_rdata <= mem_dta_out;
        end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized transaction-level check of dmem_arbiter against a memory/readback model.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic clk = 0, rst = 1;
    logic p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
    logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
    logic p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err;
    logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_dta_write, mem_dta_out;
    logic mem_read, mem_write;

    logic [31:0] mem [32];
    logic [31:0] ref_mem [32];
    logic [31:0] ref_rdata [2];
    int rd_cnt = 0, wr_cnt = 0, errors = 0, checks = 0;

    dmem_arbiter #(.DEPTH_WORDS(32), .DEBUG(1)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_dta_write(mem_dta_write), .mem_read(mem_read),
        .mem_write(mem_write), .mem_dta_out(mem_dta_out)
    );

    always #5 clk = ~clk;

    assign mem_dta_out = mem[mem_addr[6:2]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // memory model: writes land at the negedge inside the strobe cycle
    always @(negedge clk) begin
        if (mem_write) mem[mem_addr[6:2]] <= mem_dta_write;
        if (mem_read) rd_cnt++;
        if (mem_write) wr_cnt++;
        if (!rst) chk("strobe_excl", 32'(mem_read && mem_write), 0);
    end

    assert property (@(posedge clk) !(mem_read && mem_write));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d; end
        else begin p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d; end
    endtask

    // one complete transaction from requester p, checked cycle by cycle
    task automatic access(input int p, input bit we, input logic [31:0] a, input logic [31:0] d);
        bit bad;
        int r0, w0;
        bad = a[1:0] != 0 || (a >> 2) >= 32;
        r0 = rd_cnt;
        w0 = wr_cnt;
        drive(p, 1, we, a, d);
        tick;
        chk("gnt", 32'(p == 0 ? p0_gnt : p1_gnt), 1);
        chk("other_gnt", 32'(p == 0 ? p1_gnt : p0_gnt), 0);
        drive(p, 0, we, a, d);
        tick;
        if (bad) begin
            chk("err_done", 32'(p == 0 ? p0_done : p1_done), 1);
            chk("err_flag", 32'(p == 0 ? p0_err : p1_err), 1);
        end else begin
            chk("mem_read", 32'(mem_read), 32'(!we));
            chk("mem_write", 32'(mem_write), 32'(we));
            chk("mem_addr", mem_addr, a);
            if (we) chk("mem_wdata", mem_dta_write, d);
            tick;
            chk("done", 32'(p == 0 ? p0_done : p1_done), 1);
            chk("no_err", 32'(p == 0 ? p0_err : p1_err), 0);
            if (we) ref_mem[a >> 2] = d;
            else ref_rdata[p] = ref_mem[a >> 2];
        end
        chk("other_done", 32'(p == 0 ? p1_done : p0_done), 0);
        chk("rdata0", p0_rdata, ref_rdata[0]);
        chk("rdata1", p1_rdata, ref_rdata[1]);
        tick;
        chk("done_clear", 32'(p0_done || p1_done || p0_err || p1_err), 0);
        chk("reads", 32'(rd_cnt - r0), 32'(!bad && !we));
        chk("writes", 32'(wr_cnt - w0), 32'(!bad && we));
    endtask

    initial begin
        int k, p, grants, exp_win;
        logic [31:0] a;
        for (int i = 0; i < 32; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[2] = 32'hAA;
        ref_mem[2] = 32'hAA;
        ref_rdata[0] = 0;
        ref_rdata[1] = 0;
        tick;
        tick;
        chk("rst_gnt", 32'({p0_gnt, p1_gnt}), 0);
        chk("rst_done", 32'({p0_done, p1_done, p0_err, p1_err}), 0);
        chk("rst_strobe", 32'({mem_read, mem_write}), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_dta_write, 0);
        chk("rst_rdata0", p0_rdata, 0);
        chk("rst_rdata1", p1_rdata, 0);
        rst = 0;
        tick;
        access(0, 0, 32'h08, 0);
        access(1, 1, 32'h1C, 32'hDEADBEEF);
        access(1, 0, 32'h1C, 0);
        chk("rd_deadbeef", p1_rdata, 32'hDEADBEEF);
        access(0, 0, 32'h06, 0);
        access(0, 0, 32'h80, 0);
        access(0, 0, 32'h7C, 0);
        // reset in the strobe cycle of a write: write lands, no done follows
        drive(0, 1, 1, 32'h04, 32'h5);
        tick;
        drive(0, 0, 1, 32'h04, 32'h5);
        tick;
        chk("rst_wr_strobe", 32'(mem_write), 1);
        rst = 1;
        tick;
        rst = 0;
        ref_mem[1] = 32'h5;
        ref_rdata[0] = 0;
        ref_rdata[1] = 0;
        chk("rst_mem1", mem[1], 32'h5);
        chk("rst_no_done", 32'({p0_done, p1_done, p0_err, p1_err}), 0);
        chk("rst_idle_out", 32'({p0_gnt, p1_gnt, mem_read, mem_write}), 0);
        chk("rst_idle_addr", mem_addr, 0);
        chk("rst_idle_rd", p0_rdata | p1_rdata, 0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        // both requesters hold req: winners follow the configured policy
        drive(0, 1, 0, 32'h00, 0);
        drive(1, 1, 0, 32'h04, 0);
        grants = 0;
        exp_win = 0;
        for (int c = 0; c < 40 && grants < 6; c++) begin
            tick;
            if (p0_gnt || p1_gnt) begin
                chk("tie_winner", 32'(p1_gnt), 32'(exp_win));
                chk("tie_single", 32'(p0_gnt && p1_gnt), 0);
                ref_rdata[exp_win] = ref_mem[exp_win];
                grants++;
`ifdef DMEM_ARB_RR_EN
                exp_win ^= 1;
`endif
            end
        end
        chk("tie_grants", 32'(grants), 6);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        repeat (4) tick;
        chk("tie_rdata0", p0_rdata, ref_rdata[0]);
        chk("tie_rdata1", p1_rdata, ref_rdata[1]);
        // randomized single-requester traffic
        for (int n = 0; n < 30; n++) begin
            k = $urandom_range(0, 3);
            p = $urandom_range(0, 1);
            a = k < 2 ? ($urandom_range(0, 31) << 2) :
                k == 2 ? (($urandom_range(0, 31) << 2) | $urandom_range(1, 3)) :
                ($urandom_range(32, 95) << 2);
            access(p, 1'($urandom_range(0, 1)), a, $urandom);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
